// File: rtl/johnson_decoder_if.sv
// Johnson decoder bus: sampled code plus error-clear in, decoded phase and status out.
interface johnson_decoder_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ERRW  = 8
);
  localparam int unsigned IDXW = $clog2(2 * WIDTH);

  logic                 in_valid;
  logic [WIDTH-1:0]     in_code;
  logic                 clr_err;
  logic                 out_valid;
  logic [IDXW-1:0]      out_index;
  logic [2*WIDTH-1:0]   out_onehot;
  logic                 code_err;
  logic                 step_err;
  logic                 locked;
  logic [ERRW-1:0]      err_count;

  modport master (
    output in_valid, in_code, clr_err,
    input  out_valid, out_index, out_onehot, code_err, step_err, locked, err_count
  );

  modport slave (
    input  in_valid, in_code, clr_err,
    output out_valid, out_index, out_onehot, code_err, step_err, locked, err_count
  );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson code receiver: decodes a WIDTH-bit Johnson code to a phase index and
// one-hot vector, flags illegal codes and discontinuous steps, and tracks lock.
// Optional error counter enabled by defining JOHNSON_DEC_ERRCNT_EN.
module johnson_decoder #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERRW     = 8
) (
  input logic              clk,
  input logic              rst,
  johnson_decoder_if.slave bus
);
  localparam int unsigned NST  = 2 * WIDTH;
  localparam int unsigned IDXW = $clog2(NST);
  localparam int unsigned DW   = IDXW + 1;
  localparam int unsigned ACQW = 4;

  typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t            state_q;
  logic [IDXW-1:0]   prev_q;
  logic [ACQW-1:0]   acq_q;
  logic              out_valid_q;
  logic [IDXW-1:0]   index_q;
  logic [NST-1:0]    onehot_q;
  logic              code_err_q;
  logic              step_err_q;
  logic              locked_q;

  logic              msb;
  logic              code_ok;
  int unsigned       pop;
  logic [IDXW-1:0]   idx_d;
  logic [NST-1:0]    onehot_d;
  logic [DW-1:0]     delta;
  logic              code_err_d;
  logic              step_err_d;
  logic              err_evt;

  // Decode the current sample: legality, phase index, one-hot and step distance
  always_comb begin
    msb     = bus.in_code[WIDTH-1];
    code_ok = 1'b1;
    pop     = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.in_code[i]) pop = pop + 1;
    end
    // MSB=0 must be ones packed at the LSB end; MSB=1 ones packed at the MSB end
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      if (msb ? (bus.in_code[i] && !bus.in_code[i+1])
              : (!bus.in_code[i] && bus.in_code[i+1])) code_ok = 1'b0;
    end
    idx_d           = msb ? IDXW'(NST - pop) : IDXW'(pop);
    onehot_d        = '0;
    onehot_d[idx_d] = 1'b1;
    if (idx_d >= prev_q) delta = {1'b0, idx_d} - {1'b0, prev_q};
    else                 delta = {1'b0, idx_d} + DW'(NST) - {1'b0, prev_q};
    code_err_d = bus.in_valid && !code_ok;
    step_err_d = bus.in_valid && code_ok && (state_q == ST_LOCKED) && (delta > DW'(1));
    err_evt    = code_err_d || step_err_d;
  end

  // Lock FSM with registered decoded outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNLOCKED;
      prev_q      <= '0;
      acq_q       <= '0;
      out_valid_q <= 1'b0;
      index_q     <= '0;
      onehot_q    <= '0;
      code_err_q  <= 1'b0;
      step_err_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      code_err_q  <= code_err_d;
      step_err_q  <= step_err_d;
      if (bus.in_valid) begin
        if (!code_ok) begin
          onehot_q <= '0;
          state_q  <= ST_UNLOCKED;
          acq_q    <= '0;
          locked_q <= 1'b0;
        end else begin
          index_q  <= idx_d;
          onehot_q <= onehot_d;
          prev_q   <= idx_d;
          case (state_q)
            ST_UNLOCKED: begin
              state_q  <= ST_ACQUIRE;
              acq_q    <= '0;
              locked_q <= 1'b0;
            end
            ST_ACQUIRE: begin
              if (delta == DW'(1)) begin
                if (acq_q + ACQW'(1) >= ACQW'(LOCK_CNT)) begin
                  acq_q    <= ACQW'(LOCK_CNT);
                  state_q  <= ST_LOCKED;
                  locked_q <= 1'b1;
                end else begin
                  acq_q <= acq_q + ACQW'(1);
                end
              end else if (delta != '0) begin
                acq_q <= '0;
              end
            end
            ST_LOCKED: begin
              if (delta > DW'(1)) begin
                state_q  <= ST_ACQUIRE;
                acq_q    <= '0;
                locked_q <= 1'b0;
              end
            end
            default: begin
              state_q  <= ST_UNLOCKED;
              acq_q    <= '0;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_index  = index_q;
  assign bus.out_onehot = onehot_q;
  assign bus.code_err   = code_err_q;
  assign bus.step_err   = step_err_q;
  assign bus.locked     = locked_q;

`ifdef JOHNSON_DEC_ERRCNT_EN
  logic [ERRW-1:0] err_q;

  // Saturating error counter; a clear in the same cycle as an error leaves 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else if (bus.clr_err) begin
      err_q <= ERRW'(err_evt);
    end else if (err_evt && (err_q != '1)) begin
      err_q <= err_q + ERRW'(1);
    end
  end

  assign bus.err_count = err_q;
`else
  logic unused_errcnt;
  assign unused_errcnt = bus.clr_err ^ err_evt;
  assign bus.err_count = '0;
`endif
endmodule
